// File: rtl/i2c_slave_regfile.sv
// I2C slave serving a 2**AW byte register file with an auto-incrementing pointer.
// Optional build macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_slave_regfile #(
    parameter logic [6:0] ADDR_SLAVE = 7'h2,
    parameter int         AW         = 4,
    parameter logic [7:0] RST_VAL    = 8'h00
) (
    input  logic          wb_clk_i,
    input  logic          arst_i,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          busy_o,
    output logic          wr_stb_o,
    output logic [AW-1:0] wr_adr_o,
    output logic [7:0]    wr_dat_o
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK,
        ST_PTR,
        ST_WDATA,
        ST_RDATA,
        ST_MACK,
        ST_IGNORE
    } state_t;

    logic          scl_m_r, scl_s_r, sda_m_r, sda_s_r;
    logic          scl_c_s, sda_c_s;
    logic          scl_p_r, sda_p_r;
    logic          scl_rise_s, scl_fall_s, start_s, stop_s;
    state_t        state_r, ack_next_r;
    logic [2:0]    bitcnt_r;
    logic [6:0]    shift_r;
    logic [7:0]    tx_r;
    logic [AW-1:0] ptr_r;
    logic          ack_drv_r, mack_ok_r;
    logic [7:0]    byte_s, rd_byte_s;
    logic [7:0]    mem_r [DEPTH];

    // Two-flop synchronizer; idle bus level is high
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            scl_m_r <= 1'b1;
            scl_s_r <= 1'b1;
            sda_m_r <= 1'b1;
            sda_s_r <= 1'b1;
        end else begin
            scl_m_r <= scl_i;
            scl_s_r <= scl_m_r;
            sda_m_r <= sda_i;
            sda_s_r <= sda_m_r;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_h_r, sda_h_r;
    logic       scl_f_r, sda_f_r;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Majority vote over three consecutive samples rejects single-cycle pulses
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            scl_h_r <= 2'b11;
            sda_h_r <= 2'b11;
            scl_f_r <= 1'b1;
            sda_f_r <= 1'b1;
        end else begin
            scl_h_r <= {scl_h_r[0], scl_s_r};
            sda_h_r <= {sda_h_r[0], sda_s_r};
            scl_f_r <= maj3(scl_s_r, scl_h_r[0], scl_h_r[1]);
            sda_f_r <= maj3(sda_s_r, sda_h_r[0], sda_h_r[1]);
        end
    end

    assign scl_c_s = scl_f_r;
    assign sda_c_s = sda_f_r;
`else
    assign scl_c_s = scl_s_r;
    assign sda_c_s = sda_s_r;
`endif

    // Previous clean line levels for edge detection
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            scl_p_r <= 1'b1;
            sda_p_r <= 1'b1;
        end else begin
            scl_p_r <= scl_c_s;
            sda_p_r <= sda_c_s;
        end
    end

    assign scl_rise_s = scl_c_s & ~scl_p_r;
    assign scl_fall_s = ~scl_c_s & scl_p_r;
    assign start_s    = scl_c_s & scl_p_r & sda_p_r & ~sda_c_s;
    assign stop_s     = scl_c_s & scl_p_r & ~sda_p_r & sda_c_s;
    assign byte_s     = {shift_r, sda_c_s};
    assign rd_byte_s  = mem_r[ptr_r];

    // Protocol FSM, register file and registered bus/host outputs
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_r    <= ST_IDLE;
            ack_next_r <= ST_PTR;
            bitcnt_r   <= 3'd0;
            shift_r    <= 7'd0;
            tx_r       <= 8'd0;
            ptr_r      <= '0;
            ack_drv_r  <= 1'b0;
            mack_ok_r  <= 1'b0;
            sda_o      <= 1'b1;
            busy_o     <= 1'b0;
            wr_stb_o   <= 1'b0;
            wr_adr_o   <= '0;
            wr_dat_o   <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= RST_VAL;
            end
        end else begin
            wr_stb_o <= 1'b0;
            if (start_s || stop_s) begin
                // Bus conditions override any state; pointer deliberately survives
                state_r   <= start_s ? ST_ADDR : ST_IDLE;
                bitcnt_r  <= 3'd0;
                ack_drv_r <= 1'b0;
                mack_ok_r <= 1'b0;
                sda_o     <= 1'b1;
                busy_o    <= 1'b0;
            end else begin
                case (state_r)
                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            shift_r  <= byte_s[6:0];
                            bitcnt_r <= bitcnt_r + 3'd1;
                            if (bitcnt_r == 3'd7) begin
                                if (byte_s[7:1] == ADDR_SLAVE) begin
                                    state_r    <= ST_ACK;
                                    busy_o     <= 1'b1;
                                    ack_next_r <= byte_s[0] ? ST_RDATA : ST_PTR;
                                end else begin
                                    state_r <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_PTR: begin
                        if (scl_rise_s) begin
                            shift_r  <= byte_s[6:0];
                            bitcnt_r <= bitcnt_r + 3'd1;
                            if (bitcnt_r == 3'd7) begin
                                ptr_r      <= byte_s[AW-1:0];
                                ack_next_r <= ST_WDATA;
                                state_r    <= ST_ACK;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (scl_rise_s) begin
                            shift_r  <= byte_s[6:0];
                            bitcnt_r <= bitcnt_r + 3'd1;
                            if (bitcnt_r == 3'd7) begin
                                mem_r[ptr_r] <= byte_s;
                                wr_stb_o     <= 1'b1;
                                wr_adr_o     <= ptr_r;
                                wr_dat_o     <= byte_s;
                                ptr_r        <= ptr_r + AW'(1);
                                ack_next_r   <= ST_WDATA;
                                state_r      <= ST_ACK;
                            end
                        end
                    end
                    ST_ACK: begin
                        // First fall drives the ACK low, second fall ends it
                        if (scl_fall_s) begin
                            if (!ack_drv_r) begin
                                sda_o     <= 1'b0;
                                ack_drv_r <= 1'b1;
                            end else begin
                                ack_drv_r <= 1'b0;
                                state_r   <= ack_next_r;
                                if (ack_next_r == ST_RDATA) begin
                                    sda_o <= rd_byte_s[7];
                                    tx_r  <= {rd_byte_s[6:0], 1'b0};
                                end else begin
                                    sda_o <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise_s) begin
                            bitcnt_r <= bitcnt_r + 3'd1;
                            if (bitcnt_r == 3'd7) begin
                                state_r <= ST_MACK;
                            end
                        end else if (scl_fall_s) begin
                            sda_o <= tx_r[7];
                            tx_r  <= {tx_r[6:0], 1'b0};
                        end
                    end
                    ST_MACK: begin
                        if (scl_rise_s) begin
                            if (!sda_c_s) begin
                                ptr_r     <= ptr_r + AW'(1);
                                mack_ok_r <= 1'b1;
                            end else begin
                                state_r <= ST_IGNORE;
                            end
                        end else if (scl_fall_s) begin
                            if (mack_ok_r) begin
                                mack_ok_r <= 1'b0;
                                state_r   <= ST_RDATA;
                                sda_o     <= rd_byte_s[7];
                                tx_r      <= {rd_byte_s[6:0], 1'b0};
                            end else begin
                                sda_o <= 1'b1;
                            end
                        end
                    end
                    ST_IGNORE: sda_o <= 1'b1;
                    ST_IDLE:   sda_o <= 1'b1;
                    default: begin
                        state_r <= ST_IDLE;
                        sda_o   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged I2C master with immediate-assertion checks.
module tb_i2c_slave_regfile;

    logic       clk = 1'b0;
    logic       arst, scl, sda;
    logic       sda_o, busy_o, wr_stb_o;
    logic [3:0] wr_adr_o;
    logic [7:0] wr_dat_o;

    int checks = 0;
    int errors = 0;
    logic [11:0] wr_q [$];
    logic        ack;
    logic [7:0]  d;

    i2c_slave_regfile #(.ADDR_SLAVE(7'h2), .AW(4), .RST_VAL(8'h00)) dut (
        .wb_clk_i (clk),
        .arst_i   (arst),
        .scl_i    (scl),
        .sda_i    (sda),
        .sda_o    (sda_o),
        .busy_o   (busy_o),
        .wr_stb_o (wr_stb_o),
        .wr_adr_o (wr_adr_o),
        .wr_dat_o (wr_dat_o)
    );

    always #5 clk = ~clk;

    // Log every host write strobe
    always @(negedge clk) begin
        if (wr_stb_o === 1'b1) wr_q.push_back({wr_adr_o, wr_dat_o});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pop_wr();
        if (wr_q.size() == 0) return 12'hFFF;
        return wr_q.pop_front();
    endfunction

    task automatic i2c_start();
        sda = 1'b1; tick(4);
        scl = 1'b1; tick(8);
        sda = 1'b0; tick(8);
        scl = 1'b0; tick(4);
    endtask

    task automatic i2c_stop();
        sda = 1'b0; tick(4);
        scl = 1'b1; tick(8);
        sda = 1'b1; tick(8);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) begin
            sda = b[i]; tick(4);
            scl = 1'b1; tick(8);
            scl = 1'b0; tick(4);
        end
        sda = 1'b1; tick(4);
        scl = 1'b1; tick(4);
        a = sda_o;
        tick(4);
        scl = 1'b0; tick(4);
    endtask

    task automatic rd_byte(input logic a, output logic [7:0] b);
        sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(4);
            scl = 1'b1; tick(4);
            b[i] = sda_o;
            tick(4);
            scl = 1'b0; tick(4);
        end
        sda = a; tick(4);
        scl = 1'b1; tick(8);
        scl = 1'b0; tick(4);
        sda = 1'b1;
    endtask

    initial begin
        arst = 1'b0; scl = 1'b1; sda = 1'b1;
        tick(4);
        check("rst_sda", sda_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_stb", wr_stb_o, 0);
        check("rst_adr", wr_adr_o, 0);
        check("rst_dat", wr_dat_o, 0);
        arst = 1'b1; tick(4);

        // 1: read all 16 bytes from reset pointer 0
        i2c_start();
        wr_byte(8'h05, ack); check("t1_addr_ack", ack, 0);
        for (int i = 0; i < 16; i++) begin
            rd_byte(i == 15, d);
            check($sformatf("t1_reg%0d", i), d, 8'h00);
        end
        i2c_stop(); tick(4);
        check("t1_busy", busy_o, 0);

        // 2: write ptr 3, A5, 5A
        i2c_start();
        wr_byte(8'h04, ack); check("t2_addr_ack", ack, 0);
        check("t2_busy_hi", busy_o, 1);
        wr_byte(8'h03, ack); check("t2_ptr_ack", ack, 0);
        wr_byte(8'hA5, ack); check("t2_d0_ack", ack, 0);
        wr_byte(8'h5A, ack); check("t2_d1_ack", ack, 0);
        i2c_stop(); tick(4);
        check("t2_busy_lo", busy_o, 0);
        check("t2_sda", sda_o, 1);
        check("t2_nwr", wr_q.size(), 2);
        check("t2_wr0", pop_wr(), 12'h3A5);
        check("t2_wr1", pop_wr(), 12'h45A);

        // 3: pointer write, repeated START, read A5 (ACK) then 5A (NACK)
        i2c_start();
        wr_byte(8'h04, ack); check("t3_addr_ack", ack, 0);
        wr_byte(8'h03, ack); check("t3_ptr_ack", ack, 0);
        i2c_start();
        wr_byte(8'h05, ack); check("t3_raddr_ack", ack, 0);
        rd_byte(1'b0, d); check("t3_rd0", d, 8'hA5);
        rd_byte(1'b1, d); check("t3_rd1", d, 8'h5A);
        tick(2);
        check("t3_released", sda_o, 1);
        i2c_stop(); tick(4);
        check("t3_nwr", wr_q.size(), 0);

        // 4: foreign address is not acknowledged
        i2c_start();
        wr_byte(8'h06, ack); check("t4_addr_nack", ack, 1);
        check("t4_busy", busy_o, 0);
        wr_byte(8'hFF, ack); check("t4_data_nack", ack, 1);
        i2c_stop(); tick(4);
        check("t4_nwr", wr_q.size(), 0);

        // 5: pointer wrap on write and read
        i2c_start();
        wr_byte(8'h04, ack);
        wr_byte(8'h0F, ack);
        wr_byte(8'h11, ack); check("t5_d0_ack", ack, 0);
        wr_byte(8'h22, ack); check("t5_d1_ack", ack, 0);
        i2c_stop(); tick(4);
        check("t5_wr0", pop_wr(), 12'hF11);
        check("t5_wr1", pop_wr(), 12'h022);
        i2c_start();
        wr_byte(8'h04, ack);
        wr_byte(8'h0F, ack);
        i2c_start();
        wr_byte(8'h05, ack);
        rd_byte(1'b0, d); check("t5_rd15", d, 8'h11);
        rd_byte(1'b1, d); check("t5_rd0", d, 8'h22);
        i2c_stop(); tick(4);

        // 6: reset mid-byte in WDATA aborts and clears the file
        i2c_start();
        wr_byte(8'h04, ack);
        wr_byte(8'h07, ack);
        for (int i = 0; i < 4; i++) begin
            sda = 1'b1; tick(4);
            scl = 1'b1; tick(8);
            scl = 1'b0; tick(4);
        end
        check("t6_busy_pre", busy_o, 1);
        arst = 1'b0; tick(1);
        check("t6_sda", sda_o, 1);
        check("t6_busy", busy_o, 0);
        sda = 1'b1; scl = 1'b1; tick(4);
        arst = 1'b1; tick(4);
        check("t6_nwr", wr_q.size(), 0);
        i2c_start();
        wr_byte(8'h04, ack); check("t6_addr_ack", ack, 0);
        wr_byte(8'h02, ack);
        wr_byte(8'h77, ack);
        i2c_stop(); tick(4);
        check("t6_wr", pop_wr(), 12'h277);
        i2c_start();
        wr_byte(8'h04, ack);
        wr_byte(8'h02, ack);
        i2c_start();
        wr_byte(8'h05, ack);
        rd_byte(1'b0, d); check("t6_rd2", d, 8'h77);
        rd_byte(1'b1, d); check("t6_rd3", d, 8'h00);
        i2c_stop(); tick(4);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // One-cycle SDA low pulse with SCL high must not look like START
        sda = 1'b0; tick(1);
        sda = 1'b1; tick(8);
        scl = 1'b0; tick(4);
        wr_byte(8'h04, ack); check("glitch_nack", ack, 1);
        check("glitch_busy", busy_o, 0);
        i2c_stop(); tick(4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
